// File: rtl/bus_rr_sequencer_pkg.sv
// Shared types and defaults for the main-bus round-robin sequencer.
package bus_rr_sequencer_pkg;

  localparam int NUM_MASTERS             = 4;
  localparam int DEFAULT_CLK_MAX_TIMEOUT = 12;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    STROBE,
    RELEASE,
    ERROR
  } arb_state_t;

endpackage

// File: rtl/bus_rr_sequencer_picker.sv
// rr_priority_picker: combinational round-robin pick, searching from index last+1
// upward (wrapping) and returning the first requester as one-hot, index and valid.
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int cand;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last) + k) % N;
      if (!valid && req[IW'(cand)]) begin
        valid = 1'b1;
        idx   = IW'(cand);
      end
    end
    if (valid) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/bus_rr_sequencer.sv
// Round-robin arbiter and transaction sequencer for the 16-bit main bus.
// Build option BUS_RR_STICKY_ERROR_EN turns error_o into a flag held until reset.
module bus_rr_sequencer #(
  parameter int NUM_MASTERS     = bus_rr_sequencer_pkg::NUM_MASTERS,
  parameter int CLK_MAX_TIMEOUT = bus_rr_sequencer_pkg::DEFAULT_CLK_MAX_TIMEOUT,
  parameter int STROBE_CYCLES   = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_MASTERS-1:0] barq_i,
  input  logic                   address_valid_i,
  output logic [NUM_MASTERS-1:0] bagd_o,
  output logic                   target_ready_o,
  output logic                   data_strobe_o,
  output logic                   error_o,
  output logic                   busy_o
);
  import bus_rr_sequencer_pkg::*;

  localparam int LW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(CLK_MAX_TIMEOUT + 1);
  // GRANT lasts CLK_MAX_TIMEOUT+1 cycles before the timeout fires.
  localparam logic [CW-1:0] TIMEOUT_TERM = CW'(CLK_MAX_TIMEOUT);
  localparam logic [CW-1:0] STROBE_TERM  = CW'(STROBE_CYCLES - 1);

  arb_state_t             state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [LW-1:0]          last_grant, last_n;
  logic [NUM_MASTERS-1:0] win_n;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [LW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   on_bus_n;

  rr_priority_picker #(.N(NUM_MASTERS), .IW(LW)) u_picker (
    .req   (barq_i),
    .last  (last_grant),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // One counter serves as the decode timeout in GRANT and the strobe width in STROBE.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last_grant;
    win_n   = bagd_o;
    unique case (state)
      IDLE: if (pick_valid) begin
        state_n = GRANT;
        win_n   = pick_gnt;
        last_n  = pick_idx;
        cnt_n   = '0;
      end
      GRANT: begin
        cnt_n = cnt + 1'b1;
        if ((barq_i & bagd_o) == '0) begin
          state_n = RELEASE;
        end else if (address_valid_i) begin
          state_n = STROBE;
          cnt_n   = '0;
        end else if (cnt == TIMEOUT_TERM) begin
          state_n = ERROR;
        end
      end
      STROBE: begin
        cnt_n = cnt + 1'b1;
        if (cnt == STROBE_TERM) state_n = RELEASE;
      end
      RELEASE: state_n = IDLE;
      ERROR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign on_bus_n = (state_n == GRANT) || (state_n == STROBE);

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      last_grant     <= LW'(NUM_MASTERS - 1);
      bagd_o         <= '0;
      target_ready_o <= 1'b0;
      data_strobe_o  <= 1'b0;
      error_o        <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state          <= state_n;
      cnt            <= cnt_n;
      last_grant     <= last_n;
      bagd_o         <= on_bus_n ? win_n : '0;
      target_ready_o <= on_bus_n;
      data_strobe_o  <= (state_n == STROBE);
      busy_o         <= (state_n != IDLE);
`ifdef BUS_RR_STICKY_ERROR_EN
      error_o        <= error_o | (state_n == ERROR);
`else
      error_o        <= (state_n == ERROR);
`endif
    end
  end

endmodule
